// File: rtl/sram_responder.sv
// Clocked stand-in for a 16-bit asynchronous SRAM chip: samples the active-low strobes on clk,
// commits writes when WE releases and returns read data READ_LAT cycles after the read sample.
module sram_responder #(
  parameter int          DEPTH_W  = 8,
  parameter int          READ_LAT = 2,
  parameter logic [15:0] FILL     = 16'h0000,
  parameter logic [15:0] OOR_DATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [18:0] addrbus,
  inout  wire  [15:0] databus,
  input  logic        we,
  input  logic        oe,
  input  logic        ce,
  input  logic        ub,
  input  logic        lb,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        oor_err
);

  localparam int         WORDS    = 2 ** DEPTH_W;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACC, RD_DRV} state_t;

  state_t               state;
  logic [18:0]          acc_addr;
  logic [15:0]          wr_data;
  logic                 wr_ub;
  logic                 wr_lb;
  logic [3:0]           lat_cnt;
  logic [15:0]          rd_word;
  logic [WORDS-1:0]     valid;
  logic [15:0]          mem [WORDS];

  logic                 wrq;
  logic                 rdq;
  logic                 acc_oor;
  logic [DEPTH_W-1:0]   acc_idx;
  logic [15:0]          cur_word;
  logic [15:0]          merged;
  logic                 lanes_on;
  logic                 mem_we;
  logic                 drive_en;
  logic                 addr_moved;

  assign wrq        = !ce && !we;
  assign rdq        = !ce && we && !oe;
  assign acc_oor    = |acc_addr[18:DEPTH_W];
  assign acc_idx    = acc_addr[DEPTH_W-1:0];
  assign addr_moved = (addrbus != acc_addr);
  assign cur_word   = valid[acc_idx] ? mem[acc_idx] : FILL;
  assign lanes_on   = !(wr_ub && wr_lb);

  // A byte write to a never-written word keeps FILL in the untouched lane, so the word is well defined once valid.
  assign merged = {wr_ub ? cur_word[15:8] : wr_data[15:8],
                   wr_lb ? cur_word[7:0]  : wr_data[7:0]};
  assign mem_we = (state == WR_ACT) && !wrq && !acc_oor && lanes_on;

  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc_addr <= '0;
      wr_data  <= '0;
      wr_ub    <= 1'b1;
      wr_lb    <= 1'b1;
      lat_cnt  <= '0;
      rd_word  <= '0;
      valid    <= '0;
      wr_count <= '0;
      rd_count <= '0;
      oor_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wrq) begin
            state    <= WR_ACT;
            acc_addr <= addrbus;
            wr_data  <= databus;
            wr_ub    <= ub;
            wr_lb    <= lb;
          end else if (rdq) begin
            state    <= RD_ACC;
            acc_addr <= addrbus;
            lat_cnt  <= LAT_LOAD;
          end
        end
        // The last sample taken while WE is low is the one committed when it rises.
        WR_ACT: begin
          if (wrq) begin
            acc_addr <= addrbus;
            wr_data  <= databus;
            wr_ub    <= ub;
            wr_lb    <= lb;
          end else begin
            wr_count <= wr_count + 16'd1;
            if (acc_oor) oor_err <= 1'b1;
            else if (lanes_on) valid[acc_idx] <= 1'b1;
            if (rdq) begin
              state    <= RD_ACC;
              acc_addr <= addrbus;
              lat_cnt  <= LAT_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        RD_ACC: begin
          if (wrq) begin
            state    <= WR_ACT;
            acc_addr <= addrbus;
            wr_data  <= databus;
            wr_ub    <= ub;
            wr_lb    <= lb;
          end else if (!rdq) begin
            state <= IDLE;
          end else if (addr_moved) begin
            acc_addr <= addrbus;
            lat_cnt  <= LAT_LOAD;
          end else if (lat_cnt == 4'd0) begin
            state    <= RD_DRV;
            rd_count <= rd_count + 16'd1;
            if (acc_oor) begin
              rd_word <= OOR_DATA;
              oor_err <= 1'b1;
            end else begin
              rd_word <= cur_word;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RD_DRV: begin
          if (wrq) begin
            state    <= WR_ACT;
            acc_addr <= addrbus;
            wr_data  <= databus;
            wr_ub    <= ub;
            wr_lb    <= lb;
          end else if (!rdq) begin
            state <= IDLE;
          end else if (addr_moved) begin
            state    <= RD_ACC;
            acc_addr <= addrbus;
            lat_cnt  <= LAT_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Live strobes gate the drive so any violation releases the bus without waiting for a clock edge.
  assign drive_en = (state == RD_DRV) && !ce && !oe && we;

  assign databus[15:8] = (drive_en && !ub) ? rd_word[15:8] : 8'hzz;
  assign databus[7:0]  = (drive_en && !lb) ? rd_word[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Randomized bench for sram_responder against a word-array model; released bus lanes read as 1s via a pull-up net.
module tb_sram_responder;

  localparam int          DEPTH_W  = 8;
  localparam int          READ_LAT = 2;
  localparam logic [15:0] FILL     = 16'h0000;
  localparam logic [15:0] OOR_DATA = 16'hDEAD;
  localparam logic [15:0] RELEASED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] addrbus;
  logic        we, oe, ce, ub, lb;
  logic [15:0] wr_count, rd_count;
  logic        oor_err;
  logic        tb_drv;
  logic [15:0] tb_data;
  tri1  [15:0] databus;

  assign databus = tb_drv ? tb_data : 16'hzzzz;

  sram_responder #(
    .DEPTH_W (DEPTH_W),
    .READ_LAT(READ_LAT),
    .FILL    (FILL),
    .OOR_DATA(OOR_DATA)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addrbus (addrbus),
    .databus (databus),
    .we      (we),
    .oe      (oe),
    .ce      (ce),
    .ub      (ub),
    .lb      (lb),
    .wr_count(wr_count),
    .rd_count(rd_count),
    .oor_err (oor_err)
  );

  always #5 clk = ~clk;

  logic [15:0] model_mem [2**DEPTH_W];
  logic [15:0] exp_wr;
  logic [15:0] exp_rd;
  logic        exp_oor;
  int          vectors    = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**DEPTH_W; i++) model_mem[i] = FILL;
    exp_wr  = '0;
    exp_rd  = '0;
    exp_oor = 1'b0;
  endtask

  function automatic logic is_oor(input logic [18:0] a);
    return a[18:DEPTH_W] != '0;
  endfunction

  function automatic logic [15:0] exp_word(input logic [18:0] a);
    if (is_oor(a)) return OOR_DATA;
    return model_mem[a[DEPTH_W-1:0]];
  endfunction

  function automatic logic [15:0] lane_view(input logic [15:0] w, input logic u, input logic l);
    return {u ? RELEASED[15:8] : w[15:8], l ? RELEASED[7:0] : w[7:0]};
  endfunction

  function automatic logic [18:0] oor_addr();
    return {11'($urandom_range(1, 2047)), 8'($urandom)};
  endfunction

  task automatic set_pins(input logic c, input logic w, input logic o, input logic u, input logic l,
                          input logic [18:0] a, input logic drv, input logic [15:0] d);
    ce = c; we = w; oe = o; ub = u; lb = l; addrbus = a; tb_drv = drv; tb_data = d;
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic o, input logic u, input logic l,
                               input logic [18:0] a, input logic drv, input logic [15:0] d);
    set_pins(c, w, o, u, l, a, drv, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  19'($urandom), 1'b0, 16'($urandom));
  endtask

  // Random earlier samples precede the final one; only the final sample may reach the array.
  task automatic do_write(input logic [18:0] a, input logic [15:0] d, input logic u, input logic l,
                          input int holds);
    for (int i = 0; i < holds; i++) begin
      if (i < holds - 1)
        applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                      19'($urandom_range(0, 255)), 1'b1, 16'($urandom));
      else
        applyStimulus(1'b0, 1'b0, 1'($urandom), u, l, a, 1'b1, d);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, a, 1'b0, 16'h0000);
    exp_wr = exp_wr + 16'd1;
    if (is_oor(a)) exp_oor = 1'b1;
    else begin
      if (!l) model_mem[a[DEPTH_W-1:0]][7:0]  = d[7:0];
      if (!u) model_mem[a[DEPTH_W-1:0]][15:8] = d[15:8];
    end
    checkOutput("wr_count", wr_count, exp_wr);
    checkOutput("oor_err_wr", {15'd0, oor_err}, {15'd0, exp_oor});
  endtask

  task automatic do_read(input logic [18:0] a, input logic u, input logic l, input bit rel);
    logic [15:0] w;
    w = exp_word(a);
    for (int i = 0; i <= READ_LAT; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, u, l, a, 1'b0, 16'h0000);
      if (i < READ_LAT) checkOutput($sformatf("rd_wait%0d", i), databus, RELEASED);
      else              checkOutput("rd_data", databus, lane_view(w, u, l));
    end
    exp_rd = exp_rd + 16'd1;
    if (is_oor(a)) exp_oor = 1'b1;
    checkOutput("rd_count", rd_count, exp_rd);
    checkOutput("oor_err_rd", {15'd0, oor_err}, {15'd0, exp_oor});
    if (rel) begin
      idle_cycle();
      checkOutput("rd_release", databus, RELEASED);
    end
  endtask

  initial begin
    logic [18:0] a;
    logic        u, l;
    int          r;

    model_reset();
    rst_n = 1'b0;
    set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_wr_count", wr_count, 16'h0000);
    checkOutput("rst_rd_count", rd_count, 16'h0000);
    checkOutput("rst_oor_err", {15'd0, oor_err}, 16'h0000);
    checkOutput("rst_bus", databus, RELEASED);
    idle_cycle();

    do_write(19'd0, 16'h1234, 1'b0, 1'b0, 1);
    do_read(19'd0, 1'b0, 1'b0, 1);

    do_write(19'd5, 16'hAAAA, 1'b0, 1'b0, 2);
    do_write(19'd5, 16'h5555, 1'b1, 1'b0, 1);
    do_read(19'd5, 1'b0, 1'b0, 1);
    do_read(19'd5, 1'b1, 1'b0, 1);

    do_read(19'd7, 1'b0, 1'b0, 1);
    do_read(19'h00100, 1'b0, 1'b0, 1);
    idle_cycle();
    checkOutput("oor_sticky", {15'd0, oor_err}, 16'h0001);

    // Strobe violations during the drive phase must release the bus before the next edge.
    do_read(19'd5, 1'b0, 1'b0, 0);
    set_pins(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 19'd5, 1'b0, 16'h0000);
    #1;
    checkOutput("oe_release", databus, RELEASED);
    set_pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 19'd5, 1'b0, 16'h0000);
    #1;
    checkOutput("oe_restore", databus, model_mem[5]);
    set_pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'd5, 1'b0, 16'h0000);
    #1;
    checkOutput("we_release", databus, RELEASED);
    do_write(19'd5, 16'hBEEF, 1'b0, 1'b0, 2);
    idle_cycle();
    do_read(19'd5, 1'b0, 1'b0, 1);

    do_read(19'd0, 1'b0, 1'b0, 0);
    do_read(19'd1, 1'b0, 1'b0, 0);
    do_read(19'd2, 1'b0, 1'b0, 1);

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? oor_addr() : 19'($urandom_range(0, 15));
      u = 1'($urandom);
      l = 1'($urandom);
      if (r < 4) do_write(a, 16'($urandom), u, l, $urandom_range(1, 3));
      else if (r < 8) do_read(a, u, l, 1);
      else begin
        idle_cycle();
        checkOutput("idle_wr_count", wr_count, exp_wr);
        checkOutput("idle_rd_count", rd_count, exp_rd);
      end
    end

    do_read(19'd0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_read_bus", databus, RELEASED);
    checkOutput("rst_mid_read_rd", rd_count, 16'h0000);
    model_reset();
    set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle();

    do_write(19'd3, 16'h1111, 1'b0, 1'b0, 1);
    idle_cycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd3, 1'b1, 16'h7777);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd3, 1'b1, 16'h7777);
    rst_n = 1'b0;
    #1;
    model_reset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd3, 1'b1, 16'h7777);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 19'd3, 1'b0, 16'h0000);
    rst_n = 1'b1;
    idle_cycle();
    checkOutput("rst_mid_write_wr", wr_count, 16'h0000);
    do_read(19'd3, 1'b0, 1'b0, 1);
    checkOutput("post_rst_wr", wr_count, exp_wr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable stand-in for the external 16-bit asynchronous SRAM chip. It sits on the memory-side pins of our SRAM controller: addrbus, databus, and the active-low we/oe/ce/ub/lb strobes.
- Used for on-board loopback and bench co-simulation of the controller.
- Samples the strobes on the system clock, stores words in an internal array and drives read data back onto the shared bus with configurable latency.

Parameters:
- DEPTH_W, 8, internal storage is 2**DEPTH_W 16-bit words; only addrbus[DEPTH_W-1:0] is decoded.
- READ_LAT, 2, cycles from read-access sample to first bus drive (legal range 1..15).
- FILL, 16'h0000, value returned for never-written in-range locations.
- OOR_DATA, 16'hDEAD, value returned for out-of-range reads.

Ports:
- clk  input  1  system clock, all sampling on posedge.
- rst_n  input  1  asynchronous active-low reset.
- addrbus  input  19  word address from controller.
- databus  inout  16  shared data bus; driven only in RD_DRV, otherwise 16'hzzzz.
- we  input  1  write enable, active low.
- oe  input  1  output enable, active low.
- ce  input  1  chip enable, active low.
- ub  input  1  upper byte lane enable, active low.
- lb  input  1  lower byte lane enable, active low.
- wr_count  output  16  committed-write counter, wraps at 16'hFFFF.
- rd_count  output  16  completed read-access counter, wraps.
- oor_err  output  1  sticky flag: an access used addrbus[18:DEPTH_W] != 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE, wr_count=0, rd_count=0, oor_err=0, bus released, all 2**DEPTH_W per-word valid bits cleared. Array contents are not reset; reads of invalid words return FILL.
- Sample decode each posedge:
  - WRQ = ce==0 && we==0.
  - RDQ = ce==0 && we==1 && oe==0.
- States: IDLE, WR_ACT, RD_ACC, RD_DRV.
- IDLE:
  - WRQ -> WR_ACT, capture addr/data/ub/lb.
  - else RDQ -> RD_ACC, capture addr, load latency counter with READ_LAT-1.
  - else stay.
- WR_ACT (WE-controlled write, commit on strobe release):
  - While WRQ holds, recapture addr, data and lanes every cycle; the last sample wins.
  - When WRQ drops, commit the last sample in that cycle.
  - Commit writes only enabled lanes: lb=0 -> [7:0], ub=0 -> [15:8]. Both lanes disabled -> no array change, but still counted.
  - On commit: set the valid bit, wr_count+1. Out-of-range address: no array change, oor_err<=1, still counted.
  - Next state after commit: RDQ -> RD_ACC, else IDLE.
- RD_ACC:
  - Counter decrements each cycle; at 0 -> RD_DRV and latch the output word.
  - Output word = OOR_DATA (and set oor_err) if out of range; else FILL if invalid; else stored data.
  - RDQ dropping -> IDLE, no count.
  - WRQ -> WR_ACT (write takes priority).
  - Address change -> reload counter, stay.
- RD_DRV:
  - databus lanes [7:0]/[15:8] driven with the latched word only while lb/ub=0 respectively; a disabled lane is z.
  - Entry increments rd_count once.
  - Address change while RDQ -> RD_ACC (new latency).
  - RDQ drops -> IDLE.
  - WRQ -> WR_ACT.
- Bus safety: the drive enable is the registered RD_DRV state ANDed combinationally with the live ce==0, oe==0, we==1. Any strobe violation releases the bus in the same cycle, never a cycle later.
- The block never drives the bus while the controller is writing.
- Reset mid-write: the pending write is discarded and the array is untouched.
- Reset mid-read: the bus is released immediately.
- Simultaneous we=0 and oe=0 with ce=0: treated as a write; outputs z.
- ce=1 masks all other strobes; addrbus and databus are ignored.

Test Plan:
- Reset release, then ce=0, we=0, ub=lb=0, addr=0, data=16'h1234 for 1 cycle, then we=1 -> wr_count=1. Read addr 0 with READ_LAT=2: databus=16'h1234 from the 2nd cycle after the RDQ sample; rd_count=1.
- Full-word write 16'hAAAA to addr 5, then byte write ub=1 lb=0 data=16'h5555 -> read addr 5 returns 16'hAA55. Read with ub=1 -> databus[15:8]=z, [7:0]=8'h55.
- Read never-written addr 7 -> 16'h0000 (FILL). Read addr 19'h00100 (out of range for DEPTH_W=8) -> 16'hDEAD, oor_err=1 and it stays 1 until reset.
- During RD_DRV drive we=0 -> databus z in the same cycle. Commit data 16'hBEEF on we rise; a subsequent read returns 16'hBEEF.
- Hold RDQ and step addr 0->1->2 each READ_LAT+1 cycles -> each word appears after READ_LAT cycles; rd_count=3.
- Assert rst_n=0 while WR_ACT holds addr 3 data 16'h7777 -> read addr 3 returns FILL, wr_count=0.
